// File: rtl/count_seq_pkg.sv
// Shared types and helpers for the count sequencer and its counter bank.
package count_seq_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A requested pass count of zero still runs one pass.
    function automatic int unsigned effRepeats(input int unsigned rep);
        return (rep == 0) ? 1 : rep;
    endfunction

endpackage

// File: rtl/tff_bank.sv
// Bank of T flip-flops: each bit toggles when its t input is high.
module tff_bank #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] t,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    // Toggle the selected bits each edge; an active-low reset clears the bank.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_q <= '0;
        end else begin
            r_q <= r_q ^ t;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/count_sequencer.sv
// Run controller: latches a counting job, sequences the T-flip-flop bank
// through the requested passes and reports terminal count and completion.
module count_sequencer
    import count_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int REP_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode_up,
    input  logic [WIDTH-1:0] limit,
    input  logic [REP_W-1:0] repeats,
    input  logic             pause,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             term,
    output logic             done
);

    state_t           r_state;
    state_t           w_stateNext;
    logic             r_modeUp;
    logic [WIDTH-1:0] r_limit;
    logic [REP_W-1:0] r_repEff;
    logic [REP_W-1:0] r_passCnt;
    logic [REP_W-1:0] w_passNext;
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_qNext;
    logic [WIDTH-1:0] w_t;
    logic [WIDTH-1:0] w_startVal;
    logic [WIDTH-1:0] w_endVal;
    logic             w_term;
    logic             w_lastPass;
    logic             w_accept;

    assign w_accept   = (r_state == IDLE) && start;
    assign w_startVal = r_modeUp ? '0 : r_limit;
    assign w_endVal   = r_modeUp ? r_limit : '0;
    assign w_term     = (r_state == RUN) && (w_q == w_endVal);
    assign w_lastPass = (r_passCnt == (r_repEff - REP_W'(1)));

    // State register; reset discards any job in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Job parameters are captured only when a start is accepted in IDLE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_modeUp <= 1'b1;
            r_limit  <= '0;
            r_repEff <= REP_W'(1);
        end else if (w_accept) begin
            r_modeUp <= mode_up;
            r_limit  <= limit;
            r_repEff <= REP_W'(effRepeats(32'(repeats)));
        end
    end

    // Pass counter register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_passCnt <= '0;
        end else begin
            r_passCnt <= w_passNext;
        end
    end

    // Next state, next counter value and next pass count.
    always_comb begin
        w_stateNext = r_state;
        w_qNext     = w_q;
        w_passNext  = r_passCnt;
        unique case (r_state)
            IDLE: begin
                w_qNext = '0;
                if (start) begin
                    w_stateNext = RUN;
                    w_qNext     = mode_up ? '0 : limit;
                    w_passNext  = '0;
                end
            end
            RUN: begin
                if (!pause) begin
                    if (w_term) begin
                        if (w_lastPass) begin
                            w_stateNext = DONE;
                            w_qNext     = '0;
                        end else begin
                            w_qNext    = w_startVal;
                            w_passNext = r_passCnt + REP_W'(1);
                        end
                    end else if (r_modeUp) begin
                        w_qNext = w_q + WIDTH'(1);
                    end else begin
                        w_qNext = w_q - WIDTH'(1);
                    end
                end
            end
            DONE: begin
                w_stateNext = IDLE;
                w_qNext     = '0;
                w_passNext  = '0;
            end
            default: begin
                w_stateNext = IDLE;
                w_qNext     = '0;
                w_passNext  = '0;
            end
        endcase
    end

    // Only bits that differ between current and next value are toggled.
    assign w_t = w_q ^ w_qNext;

    tff_bank #(
        .WIDTH(WIDTH)
    ) u_tffBank (
        .clk  (clk),
        .reset(reset),
        .t    (w_t),
        .q    (w_q)
    );

    assign q    = w_q;
    assign busy = (r_state == RUN);
    assign term = w_term;
    assign done = (r_state == DONE);

endmodule
